// File: rtl/rr_mux_stage_pkg.sv
// Shared constants and types for the registered round-robin / fixed-priority selector.
// Imported by the interface, the arbiter and the stage.
package rr_mux_stage_pkg;

  localparam int RR_ARB       = 1;
  localparam int FIXED_ARB    = 0;
  localparam int DEF_LENGTH   = 32;
  localparam int DEF_CHANNELS = 4;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

  // A single channel still needs a 1-bit select field.
  function automatic int sel_width(input int ch);
    return (ch > 1) ? $clog2(ch) : 1;
  endfunction

endpackage

// File: rtl/rr_mux_stage_if.sv
// Bundle of the per-channel request side and the registered output side of rr_mux_stage.
// The slave modport is the stage itself; master is whoever drives requests and consumes output.
interface rr_mux_stage_if
  import rr_mux_stage_pkg::*;
#(
  parameter int LENGTH   = DEF_LENGTH,
  parameter int CHANNELS = DEF_CHANNELS
);
  localparam int SEL_W = sel_width(CHANNELS);

  logic [CHANNELS*LENGTH-1:0] in_data;
  logic [CHANNELS-1:0]        in_valid;
  logic [CHANNELS-1:0]        in_ready;
  logic                       flush;
  logic [LENGTH-1:0]          out_data;
  logic [SEL_W-1:0]           out_sel;
  logic                       out_valid;
  logic                       out_ready;

  modport slave (
    input  in_data, in_valid, flush, out_ready,
    output in_ready, out_data, out_sel, out_valid
  );

  modport master (
    output in_data, in_valid, flush, out_ready,
    input  in_ready, out_data, out_sel, out_valid
  );

endinterface

// File: rtl/rr_mux_stage_arbiter.sv
// Combinational grant logic: scan from ptr (round-robin) or from 0 (fixed priority).
// A pointer outside 0..CHANNELS-1 is treated as 0.
module rr_arbiter
  import rr_mux_stage_pkg::*;
#(
  parameter  int CHANNELS = DEF_CHANNELS,
  parameter  int RR_MODE  = RR_ARB,
  localparam int SEL_W    = sel_width(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [SEL_W-1:0]    ptr,
  output logic [CHANNELS-1:0] grant,
  output logic [SEL_W-1:0]    grant_idx,
  output logic                any_grant
);

  always_comb begin
    int start;
    int idx;
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    start     = 0;
    idx       = 0;
    if ((RR_MODE == RR_ARB) && (int'(ptr) < CHANNELS)) begin
      start = int'(ptr);
    end
    for (int k = 0; k < CHANNELS; k++) begin
      idx = start + k;
      if (idx >= CHANNELS) begin
        idx = idx - CHANNELS;
      end
      if (!any_grant && req[idx]) begin
        any_grant  = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = SEL_W'(idx);
      end
    end
  end

endmodule

// File: rtl/rr_mux_stage.sv
// N-channel valid/ready selector with a one-entry output register, stall and flush.
// Owns the round-robin pointer; grant selection lives in rr_arbiter.
module rr_mux_stage
  import rr_mux_stage_pkg::*;
#(
  parameter  int LENGTH   = DEF_LENGTH,
  parameter  int CHANNELS = DEF_CHANNELS,
  parameter  int RR_MODE  = RR_ARB,
  localparam int SEL_W    = sel_width(CHANNELS)
) (
  input  logic           clk,
  input  logic           rst,
  rr_mux_stage_if.slave  bus
);

  out_state_e          state, state_nxt;
  logic [SEL_W-1:0]    rr_ptr;
  logic [CHANNELS-1:0] grant;
  logic [SEL_W-1:0]    grant_idx;
  logic                any_grant;
  logic                load_en;
  logic                accept;
  logic [LENGTH-1:0]   data_q;
  logic [SEL_W-1:0]    sel_q;

  rr_arbiter #(
    .CHANNELS (CHANNELS),
    .RR_MODE  (RR_MODE)
  ) u_arb (
    .req       (bus.in_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  // Loading is allowed when empty or when the held word leaves this cycle.
  assign load_en      = !bus.flush && ((state == ST_EMPTY) || bus.out_ready);
  assign accept       = load_en && any_grant;
  assign bus.in_ready = rst ? '0 : (grant & {CHANNELS{load_en}});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_EMPTY: begin
        if (accept) begin
          state_nxt = ST_FULL;
        end
      end
      ST_FULL: begin
        if (bus.flush) begin
          state_nxt = ST_EMPTY;
        end else if (bus.out_ready && !any_grant) begin
          state_nxt = ST_EMPTY;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
  end

  always_comb begin
    bus.out_valid = (state == ST_FULL);
    bus.out_data  = data_q;
    bus.out_sel   = sel_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      sel_q  <= '0;
      rr_ptr <= '0;
    end else if (accept) begin
      data_q <= bus.in_data[int'(grant_idx)*LENGTH +: LENGTH];
      sel_q  <= grant_idx;
      if (RR_MODE == RR_ARB) begin
        rr_ptr <= (int'(grant_idx) == CHANNELS-1) ? '0 : grant_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rr_mux_stage.sv
// Directed bench for rr_mux_stage: 4-ch round-robin, 4-ch fixed priority, 3-ch round-robin.
// Expected words are queued when a grant is expected and checked when the output register shows them.
module tb_rr_mux_stage;
  import rr_mux_stage_pkg::*;

  typedef struct {
    logic [31:0] d;
    logic [2:0]  s;
  } exp_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  exp_t q[$];
  logic [31:0] dv[3][4];

  rr_mux_stage_if #(.LENGTH(32), .CHANNELS(4)) ifa ();
  rr_mux_stage_if #(.LENGTH(32), .CHANNELS(4)) ifb ();
  rr_mux_stage_if #(.LENGTH(32), .CHANNELS(3)) ifc ();

  rr_mux_stage #(.LENGTH(32), .CHANNELS(4), .RR_MODE(RR_ARB)) u_rr4 (
    .clk (clk), .rst (rst), .bus (ifa)
  );
  rr_mux_stage #(.LENGTH(32), .CHANNELS(4), .RR_MODE(FIXED_ARB)) u_fp4 (
    .clk (clk), .rst (rst), .bus (ifb)
  );
  rr_mux_stage #(.LENGTH(32), .CHANNELS(3), .RR_MODE(RR_ARB)) u_rr3 (
    .clk (clk), .rst (rst), .bus (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input string what, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, what, obs, exp);
    end
  endtask

  task automatic set_ch(input int dut, input int ch, input logic [31:0] d, input logic v);
    dv[dut][ch] = d;
    case (dut)
      0: begin ifa.in_data[ch*32 +: 32] = d; ifa.in_valid[ch] = v; end
      1: begin ifb.in_data[ch*32 +: 32] = d; ifb.in_valid[ch] = v; end
      default: begin ifc.in_data[ch*32 +: 32] = d; ifc.in_valid[ch] = v; end
    endcase
  endtask

  task automatic set_out(input int dut, input logic ordy, input logic fl);
    case (dut)
      0: begin ifa.out_ready = ordy; ifa.flush = fl; end
      1: begin ifb.out_ready = ordy; ifb.flush = fl; end
      default: begin ifc.out_ready = ordy; ifc.flush = fl; end
    endcase
  endtask

  task automatic clear_all(input int dut);
    for (int c = 0; c < ((dut == 2) ? 3 : 4); c++) set_ch(dut, c, 32'h0, 1'b0);
  endtask

  // Called at posedge+1 with inputs driven; samples mid-cycle, updates the scoreboard, advances one cycle.
  task automatic cyc(input int dut, input logic [3:0] exp_rdy, input string tag);
    logic [3:0]  rdy;
    logic        ov, ordy, flv;
    logic [31:0] od;
    logic [2:0]  os;
    exp_t        e;
    #3;
    case (dut)
      0: begin rdy = ifa.in_ready; ov = ifa.out_valid; od = ifa.out_data;
               os = {1'b0, ifa.out_sel}; ordy = ifa.out_ready; flv = ifa.flush; end
      1: begin rdy = ifb.in_ready; ov = ifb.out_valid; od = ifb.out_data;
               os = {1'b0, ifb.out_sel}; ordy = ifb.out_ready; flv = ifb.flush; end
      default: begin rdy = {1'b0, ifc.in_ready}; ov = ifc.out_valid; od = ifc.out_data;
               os = {1'b0, ifc.out_sel}; ordy = ifc.out_ready; flv = ifc.flush; end
    endcase
    chk(tag, "in_ready", 32'(rdy), 32'(exp_rdy));
    chk(tag, "out_valid", 32'(ov), 32'(q.size() != 0));
    if (ov && q.size() != 0) begin
      chk(tag, "out_data", od, q[0].d);
      chk(tag, "out_sel", 32'(os), 32'(q[0].s));
    end
    if (flv) q.delete();
    else if (ov && ordy && q.size() != 0) void'(q.pop_front());
    for (int b = 0; b < 4; b++) begin
      if (exp_rdy[b]) begin
        e.d = dv[dut][b];
        e.s = 3'(b);
        q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    for (int dd = 0; dd < 3; dd++) begin
      clear_all(dd);
      set_out(dd, 1'b0, 1'b0);
    end
    ifa.in_valid = 4'hF;
    #1;
    chk("rst0", "in_ready", 32'(ifa.in_ready), 32'h0);
    chk("rst0", "out_valid", 32'(ifa.out_valid), 32'h0);
    chk("rst0", "out_data", ifa.out_data, 32'h0);
    chk("rst0", "out_sel", 32'(ifa.out_sel), 32'h0);
    ifa.in_valid = 4'h0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset in the middle of holding a word
    set_ch(0, 0, 32'hDEAD, 1'b1);
    cyc(0, 4'b0001, "rmid_ld");
    set_ch(0, 0, 32'hDEAD, 1'b0);
    cyc(0, 4'b0000, "rmid_hold");
    #2 rst = 1'b1;
    #1;
    chk("rmid", "out_valid", 32'(ifa.out_valid), 32'h0);
    chk("rmid", "out_data", ifa.out_data, 32'h0);
    chk("rmid", "out_sel", 32'(ifa.out_sel), 32'h0);
    q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Round-robin sweep; the first grant after reset must be channel 0
    for (int c = 0; c < 4; c++) set_ch(0, c, 32'h100 + c, 1'b1);
    set_out(0, 1'b1, 1'b0);
    for (int k = 0; k < 8; k++) cyc(0, 4'(1 << (k % 4)), "sweep");
    clear_all(0);
    cyc(0, 4'b0000, "sweep_drain");
    cyc(0, 4'b0000, "sweep_empty");

    // Stall with a held word, then release
    set_ch(0, 0, 32'h55, 1'b1);
    cyc(0, 4'b0001, "stall_ld");
    set_ch(0, 0, 32'h55, 1'b0);
    set_ch(0, 2, 32'h202, 1'b1);
    set_out(0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) cyc(0, 4'b0000, "stall");
    set_out(0, 1'b1, 1'b0);
    cyc(0, 4'b0100, "stall_rel");
    set_ch(0, 2, 32'h202, 1'b0);
    cyc(0, 4'b0000, "stall_out");

    // Flush: pointer sits at 1 after granting channel 0, so channel 3 wins next
    set_ch(0, 0, 32'h300, 1'b1);
    cyc(0, 4'b0001, "fl_ld");
    set_ch(0, 0, 32'h301, 1'b1);
    set_ch(0, 3, 32'h303, 1'b1);
    set_out(0, 1'b1, 1'b1);
    cyc(0, 4'b0000, "flush");
    set_out(0, 1'b1, 1'b0);
    cyc(0, 4'b1000, "fl_after");
    clear_all(0);
    cyc(0, 4'b0000, "fl_out");
    cyc(0, 4'b0000, "fl_empty");

    // Fixed priority: channel 1 always beats channel 3
    set_ch(1, 1, 32'h111, 1'b1);
    set_ch(1, 3, 32'h333, 1'b1);
    set_out(1, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) cyc(1, 4'b0010, "fixed");
    clear_all(1);
    cyc(1, 4'b0000, "fixed_drain");
    cyc(1, 4'b0000, "fixed_empty");

    // Three channels: 0 and 2 alternate, pointer wraps after 2
    set_ch(2, 0, 32'h400, 1'b1);
    set_ch(2, 2, 32'h402, 1'b1);
    set_out(2, 1'b1, 1'b0);
    cyc(2, 4'b0001, "wrap3");
    cyc(2, 4'b0100, "wrap3");
    cyc(2, 4'b0001, "wrap3");
    cyc(2, 4'b0100, "wrap3");
    clear_all(2);
    cyc(2, 4'b0000, "wrap3_drain");
    cyc(2, 4'b0000, "wrap3_empty");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_mux_stage.md
Name: rr_mux_stage

Overview:
- Parametrised N-channel registered selector; generalises the 2/3-input combinational muxes.
- Arbitrates among CHANNELS valid/ready sources, round-robin or fixed priority, and captures the winner into a one-entry output register.
- Used where pipeline stages share one downstream resource, e.g. IF and MEM requests onto a single memory port, or multiple writeback sources.
- Supports pipeline stall (out_ready low) and flush.

Parameters:
- LENGTH, 32, data width per channel.
- CHANNELS, 4, number of input channels (legal 2..8; non-power-of-2 allowed).
- RR_MODE, 1, 1 = round-robin arbitration, 0 = fixed priority (lowest index wins).
- SEL_W, localparam = max(1, $clog2(CHANNELS)), width of the select/pointer.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_data  in  CHANNELS*LENGTH  packed channel data; channel i at bits [i*LENGTH +: LENGTH].
- in_valid  in  CHANNELS  per-channel request.
- in_ready  out  CHANNELS  per-channel accept; combinational.
- flush  in  1  synchronous pipeline flush.
- out_data  out  LENGTH  registered selected data.
- out_sel  out  SEL_W  registered index of the channel that produced out_data.
- out_valid  out  1  output register holds valid data.
- out_ready  in  1  downstream accepts out_data this cycle.

Behaviour:
- Reset (async, any time, including mid-transfer):
  - out_valid=0, out_data=0, out_sel=0, rr_ptr=0.
  - in_ready=0 while rst is high.
- Output register states:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- load_en = !flush && (!out_valid || out_ready). This allows full throughput: one transfer per cycle while out_ready stays high.
- Grant (combinational, one-hot or zero):
  - RR_MODE=1: the first channel with in_valid set, scanning rr_ptr, rr_ptr+1, ..., wrapping modulo CHANNELS.
  - RR_MODE=0: the lowest-index valid channel.
  - No valid channel: grant=0.
- in_ready[i] = grant[i] && load_en. At most one bit is set per cycle. Channels that are not granted see in_ready=0 and must hold their data and valid.
- Accept (load_en && grant!=0), on the clock edge:
  - out_data <= in_data[g].
  - out_sel <= g.
  - out_valid <= 1.
  - If RR_MODE=1: rr_ptr <= (g==CHANNELS-1) ? 0 : g+1.
- Consume without accept (out_valid && out_ready && no grant): out_valid <= 0. out_data and out_sel hold their last values.
- Simultaneous consume and accept: the register is replaced by new data and out_valid stays 1 (back-to-back).
- Stall (out_valid && !out_ready, no flush):
  - out_data, out_sel and out_valid hold.
  - in_ready is all 0.
  - rr_ptr holds.
- Flush (highest priority after rst):
  - Next cycle out_valid=0.
  - in_ready is all 0 in the flush cycle, so no input is accepted.
  - rr_ptr is unchanged.
  - out_data and out_sel hold.
- Latency: one cycle from in_valid&&in_ready to out_valid.
- Fairness (RR_MODE=1): with all channels continuously valid and out_ready=1, grants cycle 0,1,...,CHANNELS-1,0,...
- The rr_ptr value CHANNELS..2^SEL_W-1 is unreachable. The implementation must still map it to 0 defensively.
- Inputs are assumed stable while valid and not ready. This is not checked by RTL; the bench asserts it.

Decomposition:
- Shared defines header: the RR_MODE encodings (`RR_ARB`=1, `FIXED_ARB`=0) and the default data width, alongside the existing width defines.
- One sub-module, rr_arbiter:
  - Parameters CHANNELS, RR_MODE.
  - Inputs req[CHANNELS], ptr[SEL_W].
  - Outputs grant one-hot, grant_idx[SEL_W], any_grant.
  - Purely combinational. rr_mux_stage owns rr_ptr and the output register.

Test Plan:
- Reset mid-transfer:
  - Stimulus: CHANNELS=4, out_valid=1 holding 0xDEAD, assert rst for 1 cycle asynchronously.
  - Required: out_valid=0, out_data=0, out_sel=0 immediately. After release, the first grant with all inputs valid goes to channel 0.
- Round-robin sweep:
  - Stimulus: all 4 valid, in_data[i]=0x100+i, out_ready=1, 8 cycles.
  - Required: out_data sequence 0x100,0x101,0x102,0x103,0x100,..., with out_sel matching, one per cycle.
- Fixed priority:
  - Stimulus: RR_MODE=0, channels 1 and 3 valid, out_ready=1.
  - Required: channel 1 is granted every cycle and channel 3 never.
- Stall:
  - Stimulus: out_valid=1 with data 0x55, out_ready=0 for 3 cycles, channel 2 valid.
  - Required: out_data stays 0x55 and in_ready=0000 throughout. When out_ready rises, channel 2 is accepted in the same cycle and out_data=ch2 data next cycle.
- Flush:
  - Stimulus: out_valid=1, flush=1 with channel 0 valid and out_ready=1.
  - Required: in_ready=0000 in that cycle, out_valid=0 next cycle, rr_ptr unchanged (next grant is the same channel as it would have been).
- Non-power-of-2 wrap:
  - Stimulus: CHANNELS=3, only channels 0 and 2 valid, out_ready=1.
  - Required: grants alternate 0,2,0,2. After granting channel 2 the pointer wraps to 0.
